// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b constants: idle K character, legal K codes, disparity values and
// the x/y code sets used to classify disparity and complement decisions.
package enc8b10b_pkg;

    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic       RD_NEG = 1'b0;
    localparam logic       RD_POS = 1'b1;

    // Legal K codes: K28.y for any y, plus Kx.7 for the x values in this set.
    localparam logic [4:0]  K_X28    = 5'd28;
    localparam logic [31:0] K_X7_SET = (32'd1 << 23) | (32'd1 << 27) | (32'd1 << 29) | (32'd1 << 30);

    localparam logic [31:0] U6_SET = (32'd1 << 0)  | (32'd1 << 1)  | (32'd1 << 2)  | (32'd1 << 4)  |
                                     (32'd1 << 8)  | (32'd1 << 15) | (32'd1 << 16) | (32'd1 << 23) |
                                     (32'd1 << 24) | (32'd1 << 27) | (32'd1 << 29) | (32'd1 << 30) |
                                     (32'd1 << 31);
    localparam logic [4:0]  A6_X   = 5'd7;
    localparam logic [7:0]  U4_SET = (8'd1 << 0) | (8'd1 << 4) | (8'd1 << 7);

    // Data x.7 values that need the alternate 4b code to avoid a run of five.
    localparam logic [31:0] S_NEG_SET = (32'd1 << 17) | (32'd1 << 18) | (32'd1 << 20);
    localparam logic [31:0] S_POS_SET = (32'd1 << 11) | (32'd1 << 13) | (32'd1 << 14);

endpackage

// File: rtl/enc_disp_classify.sv
// Combinational classification of one character: legal-K check, complement
// selects, alternate-code select S and the running disparity after the character.
module enc_disp_classify
    import enc8b10b_pkg::*;
(
    input  logic [7:0] data,
    input  logic       k_in,
    input  logic       rd,
    output logic       k_eff,
    output logic       k_err,
    output logic       compls6,
    output logic       compls4,
    output logic       s_bit,
    output logic       rd_next
);

    logic [4:0] x;
    logic [2:0] y;
    logic       legal_k;
    logic       u6, a6, u4, a4, rd_mid;

    always_comb begin
        x       = data[4:0];
        y       = data[7:5];
        legal_k = (x == K_X28) | ((y == 3'd7) & K_X7_SET[x]);
        k_eff   = k_in & legal_k;
        k_err   = k_in & ~legal_k;

        u6 = U6_SET[x] | ((x == K_X28) & k_eff);
        a6 = (x == A6_X) & ~k_eff;
        u4 = U4_SET[y];
        a4 = (y == 3'd3) |
             (k_eff & (x == K_X28) & ((y == 3'd1) | (y == 3'd2) | (y == 3'd5) | (y == 3'd6)));

        compls6 = rd & (u6 | a6);
        rd_mid  = rd ^ u6;
        compls4 = rd_mid & (u4 | a4);
        rd_next = rd_mid ^ u4;

        s_bit = ((y == 3'd7) & ~k_eff & ((~rd_mid & S_NEG_SET[x]) | (rd_mid & S_POS_SET[x]))) |
                ((y == 3'd7) & k_eff);
    end

endmodule

// File: rtl/enc_rd_ctrl.sv
// 8b/10b encoder front end: one registered output stage with ready/valid handshake
// and running-disparity tracking. Define ENC_RD_CTRL_IDLE_EN to fill bubbles with IDLE_K.
module enc_rd_ctrl
    import enc8b10b_pkg::*;
#(
    parameter logic       RD_INIT = 1'b0,
    parameter logic [7:0] IDLE_K  = K28_5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_k,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_buf6,
    output logic [4:0] out_buf4,
    output logic       out_compls6,
    output logic       out_compls4,
    output logic       rd,
    output logic       k_err
);

    logic [7:0] c_data;
    logic       c_k;
    logic       load;
    logic       k_eff, k_err_c, compls6_c, compls4_c, s_c, rd_next;

    assign in_ready = ~out_valid | out_ready;

    // Idle character feeds the classifier whenever no input is offered; it only
    // reaches the register when the idle-fill build allows an empty-slot load.
    assign c_data = in_valid ? in_data : IDLE_K;
    assign c_k    = in_valid ? in_k    : 1'b1;

`ifdef ENC_RD_CTRL_IDLE_EN
    assign load = in_ready;
`else
    assign load = in_ready & in_valid;
`endif

    enc_disp_classify u_classify (
        .data    (c_data),
        .k_in    (c_k),
        .rd      (rd),
        .k_eff   (k_eff),
        .k_err   (k_err_c),
        .compls6 (compls6_c),
        .compls4 (compls4_c),
        .s_bit   (s_c),
        .rd_next (rd_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_buf6    <= '0;
            out_buf4    <= '0;
            out_compls6 <= 1'b0;
            out_compls4 <= 1'b0;
            k_err       <= 1'b0;
            rd          <= RD_INIT;
        end else if (in_ready) begin
            out_valid <= load;
            if (load) begin
                out_buf6    <= {k_eff, c_data[4:0]};
                out_buf4    <= {s_c, k_eff, c_data[7:5]};
                out_compls6 <= compls6_c;
                out_compls4 <= compls4_c;
                k_err       <= k_err_c;
                rd          <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_enc_rd_ctrl.sv
// Self-checking bench for enc_rd_ctrl: directed 8b/10b cases, backpressure,
// illegal K, mid-transfer reset and randomized traffic against a reference model.
module tb_enc_rd_ctrl;

`ifdef ENC_RD_CTRL_IDLE_EN
    localparam bit IDLE = 1'b1;
`else
    localparam bit IDLE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_k = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_compls6, out_compls4, rd, k_err;
    logic [5:0] out_buf6;
    logic [4:0] out_buf4;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    logic       m_valid;
    logic       m_rd;
    logic [5:0] m_b6;
    logic [4:0] m_b4;
    logic       m_c6, m_c4, m_kerr;

    enc_rd_ctrl #(.RD_INIT(1'b0), .IDLE_K(8'hBC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_buf6(out_buf6), .out_buf4(out_buf4),
        .out_compls6(out_compls6), .out_compls4(out_compls4),
        .rd(rd), .k_err(k_err)
    );

    always #5 clk = ~clk;

    function automatic void encode(input logic [7:0] d, input logic k, input logic rd_in,
                                   output logic [5:0] b6, output logic [4:0] b4,
                                   output logic c6, output logic c4,
                                   output logic rd_out, output logic kerr);
        int x, y;
        bit legal, ke, u6, a6, u4, a4, s, mid;
        x = int'(d[4:0]);
        y = int'(d[7:5]);
        legal = (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
        ke   = k && legal;
        kerr = k && !legal;
        u6 = (x inside {0, 1, 2, 4, 8, 15, 16, 23, 24, 27, 29, 30, 31}) || (x == 28 && ke);
        a6 = (x == 7) && !ke;
        u4 = y inside {0, 4, 7};
        a4 = (y == 3) || (ke && x == 28 && (y inside {1, 2, 5, 6}));
        c6  = rd_in && (u6 || a6);
        mid = u6 ? !rd_in : rd_in;
        c4  = mid && (u4 || a4);
        rd_out = u4 ? !mid : mid;
        if (ke) s = (y == 7);
        else    s = (y == 7) && ((!mid && (x inside {17, 18, 20})) || (mid && (x inside {11, 13, 14})));
        b6 = {ke, d[4:0]};
        b4 = {s, ke, d[7:5]};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_rd = 1'b0; m_b6 = '0; m_b4 = '0;
        m_c6 = 1'b0; m_c4 = 1'b0; m_kerr = 1'b0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then step the DUT.
    task automatic tick();
        logic nrd;
        if (!m_valid || out_ready) begin
            if (in_valid || IDLE) begin
                encode(in_valid ? in_data : 8'hBC, in_valid ? in_k : 1'b1, m_rd,
                       m_b6, m_b4, m_c6, m_c4, nrd, m_kerr);
                m_rd = nrd;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        vectors++;
        if ({out_valid, k_err, out_buf6, out_buf4, out_compls6, out_compls4, rd} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0000",
                     {out_valid, k_err, out_buf6, out_buf4, out_compls6, out_compls4, rd});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({out_valid, rd} !== {m_valid, m_rd}) begin
            errors++;
            $display("FAIL post_reset: valid/rd got %b%b expected %b%b", out_valid, rd, m_valid, m_rd);
        end
    endtask

    task automatic test_directed();
        logic [8:0] seq [6];
        logic [4:0] exp_cs [6]; // {c6, c4, s, rd, k_err}
        seq[0] = {1'b0, 8'hB5}; exp_cs[0] = 5'b00000;
        seq[1] = {1'b0, 8'h00}; exp_cs[1] = 5'b01000;
        seq[2] = {1'b1, 8'hBC}; exp_cs[2] = 5'b01010;
        seq[3] = {1'b1, 8'hBC}; exp_cs[3] = 5'b10000;
        seq[4] = {1'b0, 8'hF1}; exp_cs[4] = 5'b00110;
        seq[5] = {1'b0, 8'hEB}; exp_cs[5] = 5'b01100;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_k     = seq[i][8];
            in_data  = seq[i][7:0];
            tick();
            vectors++;
            if ({out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4, k_err} !==
                {m_valid, m_rd, m_b6, m_b4, m_c6, m_c4, m_kerr}) begin
                errors++;
                $display("FAIL directed_model[%0d]: got %h expected %h", i,
                         {out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4, k_err},
                         {m_valid, m_rd, m_b6, m_b4, m_c6, m_c4, m_kerr});
            end
            if (!IDLE) begin
                vectors++;
                if ({out_compls6, out_compls4, out_buf4[4], rd, k_err} !== exp_cs[i]) begin
                    errors++;
                    $display("FAIL directed_const[%0d]: c6,c4,S,rd,kerr got %b expected %b", i,
                             {out_compls6, out_compls4, out_buf4[4], rd, k_err}, exp_cs[i]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_k = 1'b0; in_data = 8'h4A;
        tick();
        held = {out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4, k_err};
        out_ready = 1'b0;
        in_data   = 8'h27;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready);
            end
            tick();
            vectors++;
            if ({out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4, k_err} !== held ||
                held !== {m_valid, m_rd, m_b6, m_b4, m_c6, m_c4, m_kerr}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %h expected %h", i,
                         {out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4, k_err}, held);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        tick();
        vectors++;
        if ({out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4} !==
            {1'b1, m_rd, m_b6, m_b4, m_c6, m_c4} || out_buf6[4:0] !== 5'd7) begin
            errors++;
            $display("FAIL bp_next_word: got %h expected %h",
                     {out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4},
                     {1'b1, m_rd, m_b6, m_b4, m_c6, m_c4});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal_k();
        out_ready = 1'b1;
        in_valid = 1'b1; in_k = 1'b1; in_data = 8'h15;
        tick();
        vectors++;
        if ({out_valid, k_err, out_buf6, out_buf4} !== {1'b1, 1'b1, 6'b010101, 5'b00000} ||
            {rd, out_compls6, out_compls4} !== {m_rd, m_c6, m_c4}) begin
            errors++;
            $display("FAIL illegal_k: valid,kerr,b6,b4 got %b %b %b %b expected 1 1 010101 00000",
                     out_valid, k_err, out_buf6, out_buf4);
        end
        in_k = 1'b0; in_data = 8'h15;
        tick();
        vectors++;
        if (k_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_k_clear: k_err got %b expected 0", k_err);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_idle_fill();
        logic prev_rd;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            prev_rd = rd;
            tick();
            vectors++;
            if ({out_valid, rd} !== {m_valid, m_rd} ||
                (IDLE && (out_buf6 !== 6'b111100 || rd === prev_rd)) ||
                (!IDLE && rd !== prev_rd)) begin
                errors++;
                $display("FAIL idle_fill[%0d]: valid,rd,b6 got %b %b %b expected %b %b", i,
                         out_valid, rd, out_buf6, m_valid, m_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_k = 1'b1; in_data = 8'hBC;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, k_err, out_buf6, out_buf4, out_compls6, out_compls4, rd} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: got %h expected 0000",
                     {out_valid, k_err, out_buf6, out_buf4, out_compls6, out_compls4, rd});
        end
        model_reset();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({out_valid, rd} !== {m_valid, m_rd}) begin
            errors++;
            $display("FAIL reset_mid_release: valid/rd got %b%b expected %b%b", out_valid, rd, m_valid, m_rd);
        end
    endtask

    task automatic test_random();
        logic [7:0] legal_k [9];
        legal_k = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7};
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_k      = ($urandom_range(0, 4) == 0);
            if (in_k && $urandom_range(0, 1) == 1)
                in_data = legal_k[$urandom_range(0, 8)];
            else
                in_data = 8'($urandom);
            #1;
            vectors++;
            if (in_ready !== (!m_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, !m_valid || out_ready);
            end
            tick();
            vectors++;
            if ({out_valid, rd} !== {m_valid, m_rd} ||
                (m_valid && {out_buf6, out_buf4, out_compls6, out_compls4, k_err} !==
                            {m_b6, m_b4, m_c6, m_c4, m_kerr})) begin
                errors++;
                $display("FAIL rand_word[%0d]: got %h expected %h", i,
                         {out_valid, rd, out_buf6, out_buf4, out_compls6, out_compls4, k_err},
                         {m_valid, m_rd, m_b6, m_b4, m_c6, m_c4, m_kerr});
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal_k();
        test_idle_fill();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
